dc_buffer_ctrl: RTL and testbench

//   Single-clock FIFO controller that sequences a dc_data_buffer instance.
//   - Owns the one-hot write_pointer and read_pointer into the buffer.
//   - Exposes valid/ready push and pop interfaces.
//   - Tracks occupancy and reports level.
//   - Used where a same-clock elastic stage reuses the dual-clock slice storage.

---
 rtl/dc_buffer_pkg.sv | 28 ++
 rtl/dc_onehot_ptr.sv | 43 ++++
 rtl/dc_buffer_ctrl.sv | 90 +++++++++
 tb/tb_dc_buffer_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/dc_buffer_pkg.sv
// Shared helpers for the dc_buffer controller: level sizing, one-hot pointer
// rotation and the pointer reset value.
package dc_buffer_pkg;

    localparam int PTR_MAX_W = 64;
    localparam logic [PTR_MAX_W-1:0] PTR_RESET = 64'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Rotate left by one within the low 'width' bits; bit width-1 wraps to bit 0.
    function automatic logic [PTR_MAX_W-1:0] onehot_rotl(input logic [PTR_MAX_W-1:0] ptr,
                                                         input int width);
        logic [PTR_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < PTR_MAX_W; i++) begin
            if (i < width) r[(i + 1 == width) ? 0 : i + 1] = ptr[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/dc_onehot_ptr.sv
// One-hot slot pointer: synchronous clear to slot 0, rotate left on advance.
module dc_onehot_ptr
    import dc_buffer_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clear,
    input  logic         advance,
    output logic [W-1:0] ptr
);

    logic [W-1:0]         ptr_q, ptr_d;
    logic [PTR_MAX_W-1:0] wide, rot;

    // clear beats advance so a flush also drops a same-cycle push/pop.
    always_comb begin
        wide        = '0;
        wide[W-1:0] = ptr_q;
        rot         = onehot_rotl(wide, W);
        ptr_d       = ptr_q;
        if (clear)        ptr_d = PTR_RESET[W-1:0];
        else if (advance) ptr_d = rot[W-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ptr_q <= PTR_RESET[W-1:0];
        else       ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;

`ifndef SYNTHESIS
    generate
        if (W < PTR_MAX_W) begin : g_rot_chk
            a_rot_in_range: assert property (@(posedge clk) disable iff (!rstn)
                rot[PTR_MAX_W-1:W] == '0);
        end
    endgenerate
`endif

endmodule

// File: rtl/dc_buffer_ctrl.sv
// Same-clock FIFO controller sequencing a dc_data_buffer through one-hot
// write/read pointers, with valid/ready push and pop ports and a level output.
module dc_buffer_ctrl
    import dc_buffer_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 8,
    parameter int LVL_W        = clog2(BUFFER_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    flush,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic [BUFFER_DEPTH-1:0] write_pointer,
    output logic [DATA_WIDTH-1:0]   write_data,
    output logic [BUFFER_DEPTH-1:0] read_pointer,
    input  logic [DATA_WIDTH-1:0]   read_data,
    output logic [LVL_W-1:0]        level
);

    localparam logic [LVL_W-1:0] FULL = LVL_W'(BUFFER_DEPTH - 1);

    logic             rst_done_q;
    logic [LVL_W-1:0] count_q, count_d;
    logic             push, pop;

    // The buffer writes every edge, so one slot is kept free as the write target.
    assign ready_out = rst_done_q & (count_q != FULL);
    assign valid_out = (count_q != '0);
    assign push      = valid_in & ready_out;
    assign pop       = valid_out & ready_in;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + LVL_W'(1);
                2'b01:   count_d = count_q - LVL_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // rst_done holds off pushes for one edge while the buffer runs its own reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_done_q <= 1'b0;
            count_q    <= '0;
        end else begin
            rst_done_q <= 1'b1;
            count_q    <= count_d;
        end
    end

    dc_onehot_ptr #(.W(BUFFER_DEPTH)) u_wr_ptr (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (flush),
        .advance (push),
        .ptr     (write_pointer)
    );

    dc_onehot_ptr #(.W(BUFFER_DEPTH)) u_rd_ptr (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (flush),
        .advance (pop),
        .ptr     (read_pointer)
    );

    assign write_data = data_in;
    assign data_out   = read_data;
    assign level      = count_q;

`ifndef SYNTHESIS
    a_wp_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot(write_pointer));
    a_rp_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot(read_pointer));
    a_cnt_max:   assert property (@(posedge clk) disable iff (!rstn) count_q <= FULL);
    a_ptr_apart: assert property (@(posedge clk) disable iff (!rstn)
        (count_q != '0) |-> (write_pointer != read_pointer));
`endif

endmodule

// File: tb/tb_dc_buffer_ctrl.sv
// Randomised scoreboard bench for dc_buffer_ctrl with a behavioural slot buffer.
module tb_dc_buffer_ctrl;

    localparam int DW = 32;
    localparam int D  = 8;
    localparam int LW = 3;

    logic          clk, rstn, flush, valid_in, ready_out, valid_out, ready_in;
    logic [DW-1:0] data_in, data_out, write_data, read_data;
    logic [D-1:0]  write_pointer, read_pointer;
    logic [LW-1:0] level;

    dc_buffer_ctrl #(.DATA_WIDTH(DW), .BUFFER_DEPTH(D)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .flush         (flush),
        .data_in       (data_in),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .write_pointer (write_pointer),
        .write_data    (write_data),
        .read_pointer  (read_pointer),
        .read_data     (read_data),
        .level         (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slot storage: written every edge at write_pointer, read at read_pointer.
    logic [DW-1:0] mem [D];
    always @(posedge clk) begin
        for (int i = 0; i < D; i++) if (write_pointer[i]) mem[i] <= write_data;
    end
    always_comb begin
        read_data = '0;
        for (int i = 0; i < D; i++) if (read_pointer[i]) read_data = read_data | mem[i];
    end

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] sb_q[$];
    int            m_cnt  = 0;
    bit            m_done = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, check state-derived outputs, advance the model.
    task automatic step(input bit vin, input logic [DW-1:0] din, input bit rin, input bit fl);
        bit e_rdy, e_vld;
        valid_in = vin; data_in = din; ready_in = rin; flush = fl;
        e_rdy = m_done && (m_cnt < D - 1);
        e_vld = (m_cnt != 0);
        check("ready_out", {63'b0, ready_out}, {63'b0, e_rdy});
        check("valid_out", {63'b0, valid_out}, {63'b0, e_vld});
        check("level", 64'(level), 64'(m_cnt));
        if (fl) begin
            sb_q.delete();
            m_cnt = 0;
        end else begin
            if (vin && e_rdy) begin sb_q.push_back(din); m_cnt++; end
            if (rin && e_vld) m_cnt--;
        end
        @(posedge clk); #1;
        if (rstn) m_done = 1'b1;
    endtask

    task automatic drain();
        while (m_cnt > 0) step(1'b0, '0, 1'b1, 1'b0);
        check("sb_leftover", 64'(sb_q.size()), 64'd0);
    endtask

    // Monitor: every pop the DUT performs must deliver the oldest expected word.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (rstn && valid_out && ready_in && !flush) begin
            if (sb_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL pop_data: got %h expected no word at %0t", data_out, $time);
            end else begin
                e = sb_q.pop_front();
                check("pop_data", 64'(data_out), 64'(e));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wp", 64'(write_pointer), 64'h1);
        check("rst_rp", 64'(read_pointer), 64'h1);
        check("rst_ready", {63'b0, ready_out}, 64'd0);
        check("rst_valid", {63'b0, valid_out}, 64'd0);
        rstn = 1'b1;

        // 1: first edge refuses, next accepts; word visible one cycle later
        step(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
        step(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
        check("t1_data", 64'(data_out), 64'hA5A5_0001);
        step(1'b0, '0, 1'b0, 1'b0);
        drain();

        // 2: fill to capacity from a flushed state
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 1; i <= 7; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        check("t2_wp", 64'(write_pointer), 64'h80);
        check("t2_rp", 64'(read_pointer), 64'h01);
        check("t2_level", 64'(level), 64'd7);

        // 3: pop at full refuses the concurrent push; it lands next cycle
        step(1'b1, 32'h8, 1'b1, 1'b0);
        step(1'b1, 32'h8, 1'b0, 1'b0);
        drain();

        // 4: steady streaming at level 3 with pointer wrap
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, $urandom, 1'b1, 1'b0);
        check("t4_level", 64'(level), 64'd3);
        drain();

        // 5: flush at level 5 drops the concurrent push
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        check("t5_wp", 64'(write_pointer), 64'h1);
        check("t5_rp", 64'(read_pointer), 64'h1);
        check("t5_valid", {63'b0, valid_out}, 64'd0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0));

        // 6: async reset between edges while holding data
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        #1 rstn = 1'b0;
        #1;
        check("t6_ready", {63'b0, ready_out}, 64'd0);
        check("t6_valid", {63'b0, valid_out}, 64'd0);
        check("t6_level", 64'(level), 64'd0);
        check("t6_wp", 64'(write_pointer), 64'h1);
        check("t6_rp", 64'(read_pointer), 64'h1);
        sb_q.delete(); m_cnt = 0; m_done = 1'b0;
        rstn = 1'b1;
        step(1'b1, $urandom, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++)
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
